// File: rtl/data_sram_resp.sv
// Word-addressed data SRAM responder with a small MMIO window:
// LED register, synchronized switches and a free-running timer.
module data_sram_resp #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [15:0] MMIO_BASE  = 16'h1FAF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sram_en,
    input  logic [3:0]  sram_wen,
    input  logic [31:0] sram_addr,
    input  logic [31:0] sram_wdata,
    output logic [31:0] sram_rdata,
    output logic [15:0] led,
    input  logic [15:0] switch
);

    localparam logic [15:0] OFF_LED   = 16'hF000;
    localparam logic [15:0] OFF_SW    = 16'hF004;
    localparam logic [15:0] OFF_TIMER = 16'hE000;
    localparam int          DEPTH     = 2 ** ADDR_WIDTH;

    logic [31:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;
    logic [15:0]           off;
    logic                  is_mmio;
    logic                  rd_req;
    logic                  wr_req;
    logic                  timer_wr;
    logic                  led_wr;
    logic [31:0]           timer;
    logic [31:0]           rd_val;
    logic [15:0]           sw_meta;
    logic [15:0]           sw_sync;

    function automatic logic [31:0] byte_merge(
        input logic [31:0] cur,
        input logic [31:0] nxt,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? nxt[8*i +: 8] : cur[8*i +: 8];
        end
        return res;
    endfunction

    // Address decode; upper RAM address bits alias, low two bits ignored.
    assign idx      = sram_addr[ADDR_WIDTH+1:2];
    assign off      = sram_addr[15:0];
    assign is_mmio  = (sram_addr[31:16] == MMIO_BASE);
    assign rd_req   = sram_en && (sram_wen == 4'b0000);
    assign wr_req   = sram_en && (sram_wen != 4'b0000);
    assign timer_wr = wr_req && is_mmio && (off == OFF_TIMER);
    assign led_wr   = wr_req && is_mmio && (off == OFF_LED);

    // Select the word a read in this cycle returns.
    always_comb begin
        rd_val = '0;
        if (is_mmio) begin
            case (off)
                OFF_LED:   rd_val = {16'h0, led};
                OFF_SW:    rd_val = {16'h0, sw_sync};
                OFF_TIMER: rd_val = timer;
                default:   rd_val = '0;
            endcase
        end else begin
            rd_val = mem[idx];
        end
    end

    // Registered read data; holds across idle and write cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            sram_rdata <= '0;
        end else if (rd_req) begin
            sram_rdata <= rd_val;
        end
    end

    // RAM byte-masked write; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_req && !is_mmio) begin
            mem[idx] <= byte_merge(mem[idx], sram_wdata, sram_wen);
        end
    end

    // LED register; only the low two byte enables matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            led <= '0;
        end else if (led_wr) begin
            if (sram_wen[0]) led[7:0]  <= sram_wdata[7:0];
            if (sram_wen[1]) led[15:8] <= sram_wdata[15:8];
        end
    end

    // Timer counts every cycle unless software overwrites it.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
        end else if (timer_wr) begin
            timer <= byte_merge(timer, sram_wdata, sram_wen);
        end else begin
            timer <= timer + 32'd1;
        end
    end

    // Two-flop synchronizer for the asynchronous switches.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= switch;
            sw_sync <= sw_meta;
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: a reference model predicts
// each read at issue time; results are popped one cycle later.
module tb_data_sram_resp;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic [15:0] led;
    logic [15:0] switch;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] ram_m[int unsigned];
    logic [15:0] led_m;
    logic [15:0] s1_m;
    logic [15:0] s2_m;
    logic [31:0] tm_m;
    logic [31:0] last_m;

    data_sram_resp #(.ADDR_WIDTH(AW), .MMIO_BASE(16'h1FAF)) dut (
        .clk(clk),
        .rst(rst),
        .sram_en(sram_en),
        .sram_wen(sram_wen),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .led(led),
        .switch(switch)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] wmerge(input logic [31:0] cur,
                                           input logic [31:0] nw,
                                           input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (cur & ~m) | (nw & m);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned k;
        if (a[31:16] == 16'h1FAF) begin
            if (a[15:0] == 16'hF000) return {16'h0, led_m};
            if (a[15:0] == 16'hF004) return {16'h0, s2_m};
            if (a[15:0] == 16'hE000) return tm_m;
            return 32'h0;
        end
        k = (a >> 2) & ((1 << AW) - 1);
        if (ram_m.exists(k)) return ram_m[k];
        return 32'h0;
    endfunction

    // One clock cycle: drive, predict, advance model, compare.
    task automatic step(input logic en, input logic [3:0] wen,
                        input logic [31:0] a, input logic [31:0] wd);
        bit rd;
        bit twr;
        int unsigned k;
        sram_en    = en;
        sram_wen   = wen;
        sram_addr  = a;
        sram_wdata = wd;
        rd = en && (wen == 4'b0) && !rst;
        if (rd) exp_q.push_back(model_read(a));
        @(posedge clk);
        if (rst) begin
            led_m  = 16'h0;
            tm_m   = 32'h0;
            s1_m   = 16'h0;
            s2_m   = 16'h0;
            last_m = 32'h0;
        end else begin
            s2_m = s1_m;
            s1_m = switch;
            twr = 1'b0;
            if (en && wen != 4'b0) begin
                if (a[31:16] == 16'h1FAF) begin
                    if (a[15:0] == 16'hF000)
                        led_m = wmerge({16'h0, led_m}, wd,
                                       {2'b00, wen[1:0]}) & 32'hFFFF;
                    if (a[15:0] == 16'hE000) begin
                        tm_m = wmerge(tm_m, wd, wen);
                        twr = 1'b1;
                    end
                end else begin
                    k = (a >> 2) & ((1 << AW) - 1);
                    ram_m[k] = wmerge(ram_m.exists(k) ? ram_m[k] : 32'h0,
                                      wd, wen);
                end
            end
            if (!twr) tm_m = tm_m + 1;
            if (rd) last_m = exp_q.pop_front();
        end
        #1;
        check("rdata", sram_rdata, last_m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  w;
        rst = 1'b1;
        switch = 16'h0;
        led_m = 0; tm_m = 0; s1_m = 0; s2_m = 0; last_m = 0;
        // Requests during reset must be ignored.
        step(1'b1, 4'hF, 32'h1FAFF000, 32'hFFFFFFFF);
        step(1'b1, 4'h0, 32'h1FAFE000, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
        rst = 1'b0;

        // Timer counts from 0 on the first released cycle.
        idle(9);
        step(1'b1, 4'h0, 32'h1FAFE000, 32'h0);
        check("timer9", sram_rdata, 32'h9);
        step(1'b1, 4'hF, 32'h1FAFE000, 32'hFFFFFFFE);
        idle(2);
        step(1'b1, 4'h0, 32'h1FAFE000, 32'h0);
        check("timer_wrap", sram_rdata, 32'h0);
        step(1'b1, 4'h3, 32'h1FAFE000, 32'h00005555);
        step(1'b1, 4'h0, 32'h1FAFE000, 32'h0);

        // Byte-merged RAM writes, write-then-read forwarding.
        step(1'b1, 4'hF, 32'h00000010, 32'hDEADBEEF);
        step(1'b1, 4'h2, 32'h00000010, 32'h00005500);
        step(1'b1, 4'h0, 32'h00000010, 32'h0);
        check("merge", sram_rdata, 32'hDEAD55EF);
        step(1'b1, 4'hF, 32'h00000020, 32'h11111111);
        step(1'b1, 4'h0, 32'h00000020, 32'h0);
        step(1'b1, 4'h0, 32'h00000020 + (4 << AW), 32'h0);
        check("alias", sram_rdata, 32'h11111111);
        step(1'b1, 4'h0, 32'h00000023, 32'h0);

        // Disabled request with write enables must not write.
        step(1'b0, 4'hF, 32'h00000020, 32'hBADBAD00);
        step(1'b1, 4'h0, 32'h00000020, 32'h0);

        // LED write must not alias into RAM.
        step(1'b1, 4'hF, 32'h00003000, 32'hCAFEF00D);
        step(1'b1, 4'hF, 32'h1FAFF000, 32'hABCD1234);
        check("led", {16'h0, led}, 32'h00001234);
        step(1'b1, 4'h0, 32'h1FAFF000, 32'h0);
        step(1'b1, 4'h0, 32'h00003000, 32'h0);
        step(1'b1, 4'h4, 32'h1FAFF000, 32'h00FF0000);
        step(1'b1, 4'h2, 32'h1FAFF000, 32'h00007700);
        step(1'b1, 4'h0, 32'h1FAFF000, 32'h0);

        // Switch synchronizer and read-only behaviour.
        switch = 16'h00A5;
        idle(2);
        step(1'b1, 4'h0, 32'h1FAFF004, 32'h0);
        step(1'b1, 4'hF, 32'h1FAFF004, 32'h0);
        step(1'b1, 4'h0, 32'h1FAFF004, 32'h0);

        // Unmapped MMIO offset: reads zero, RAM untouched.
        step(1'b1, 4'hF, 32'h1FAF0020, 32'h0BAD0BAD);
        step(1'b1, 4'h0, 32'h1FAF0020, 32'h0);
        step(1'b1, 4'h0, 32'h00000020, 32'h0);

        // Back-to-back random traffic over a small word set.
        for (int i = 0; i < 4; i++)
            step(1'b1, 4'hF, 32'h100 + 4 * i, $urandom);
        for (int i = 0; i < 60; i++) begin
            a = 32'h100 + 4 * $urandom_range(0, 3);
            w = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom);
            step(1'b1, w, a, $urandom);
        end

        // Reset right after a read discards the pending data.
        step(1'b1, 4'hF, 32'h00000040, 32'h12345678);
        step(1'b1, 4'h0, 32'h00000040, 32'h0);
        check("pre_rst", sram_rdata, 32'h12345678);
        rst = 1'b1;
        step(1'b0, 4'h0, 32'h0, 32'h0);
        check("rst_rdata", sram_rdata, 32'h0);
        check("rst_led2", {16'h0, led}, 32'h0);
        rst = 1'b0;
        step(1'b1, 4'h0, 32'h1FAFE000, 32'h0);
        check("rst_timer", sram_rdata, 32'h0);
        step(1'b1, 4'h0, 32'h00000040, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
